// File: rtl/iecdrv_pkg.sv
// Shared definitions for the drive ROM fetch path: ROM image geometry and
// the fetch state encoding.
package iecdrv_pkg;

  // One drive ROM image is 32 KiB, addressed by a 15-bit byte counter
  localparam int ROM_BYTES = 32768;
  localparam int ROM_AW    = 15;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/iecdrv_rom_fetch_if.sv
// Signal bundle between the ROM fetcher, the memory arbiter and the ROM
// loader. The master side is the fetcher; the slave side is the environment
// (the loader's request/bank lines plus the memory port).
interface iecdrv_rom_fetch_if #(
  parameter int ADDR_W = 25
);
  import iecdrv_pkg::*;

  // Loader side
  logic [3:0]        rom_bank;
  logic              rom_req;
  logic              rom_wr;
  logic [7:0]        rom_data;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [7:0]        mem_dout;
  // Status
  logic              busy;
  logic              done;

  modport master (
    input  rom_bank, rom_req, mem_ack, mem_dout,
    output rom_wr, rom_data, mem_addr, mem_rd, busy, done
  );

  modport slave (
    output rom_bank, rom_req, mem_ack, mem_dout,
    input  rom_wr, rom_data, mem_addr, mem_rd, busy, done
  );

endinterface

// File: rtl/iecdrv_rom_fetch.sv
// Drive ROM fetcher: when the loader raises rom_req, stream the 32 KiB image
// of the selected bank from the shared memory port as one-cycle rom_wr
// writes. A bank change or a dropped request aborts cleanly (an outstanding
// memory read is always completed and its data discarded).
//
// Build option: IECDRV_FETCH_FILL_EN -- banks at or above NUM_BANKS are not
// read from memory; the image is synthesised as all 8'hFF so the loader can
// recognise the bank as empty.
module iecdrv_rom_fetch
  import iecdrv_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int          NUM_BANKS = 16,
  parameter int          ADDR_W    = 25
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  iecdrv_rom_fetch_if.master    bus
);

  localparam logic [ADDR_W-1:0] BASE_W   = ADDR_W'(BASE_ADDR);
  localparam logic [ROM_AW-1:0] CNT_LAST = ROM_AW'(ROM_BYTES - 1);

`ifdef IECDRV_FETCH_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  fetch_state_t      state_reg;
  logic [ROM_AW-1:0] cnt_reg;
  logic [3:0]        bank_q_reg;
  logic              drop_reg;   // outstanding read must be discarded
  logic              rearm_reg;  // rom_req seen low while in DONE

  logic              bank_changed;
  logic              bank_absent;
  logic              fill_now;
  logic [ADDR_W-1:0] rd_addr;

  // Bank n occupies BASE_ADDR + n*32768 .. +32767; address wraps at ADDR_W bits
  assign bank_changed = (bus.rom_bank != bank_q_reg);
  assign bank_absent  = ({1'b0, bank_q_reg} >= 5'(NUM_BANKS));
  assign fill_now     = FILL_EN && bank_absent;
  assign rd_addr      = BASE_W + ADDR_W'({bank_q_reg, cnt_reg});

  // Fetch sequencer: counter, bank latch and all registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bank_q_reg   <= '0;
      drop_reg     <= 1'b0;
      rearm_reg    <= 1'b0;
      bus.rom_wr   <= 1'b0;
      bus.rom_data <= '0;
      bus.mem_addr <= '0;
      bus.mem_rd   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.rom_wr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.rom_req) begin
            bank_q_reg <= bus.rom_bank;
            cnt_reg    <= '0;
            drop_reg   <= 1'b0;
            bus.busy   <= 1'b1;
            bus.done   <= 1'b0;
            state_reg  <= ISSUE;
          end
        end

        ISSUE: begin
          if (bank_changed || !bus.rom_req) begin
            // Nothing outstanding yet, so the abort is immediate
            cnt_reg   <= '0;
            bus.busy  <= 1'b0;
            state_reg <= IDLE;
          end else if (fill_now) begin
            bus.rom_data <= 8'hFF;
            bus.rom_wr   <= 1'b1;
            state_reg    <= WRITE;
          end else begin
            bus.mem_addr <= rd_addr;
            bus.mem_rd   <= 1'b1;
            state_reg    <= WAIT;
          end
        end

        WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_rd <= 1'b0;
            if (drop_reg || bank_changed || !bus.rom_req) begin
              // Handshake finished; the byte belongs to an abandoned transfer
              drop_reg  <= 1'b0;
              cnt_reg   <= '0;
              bus.busy  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              bus.rom_data <= bus.mem_dout;
              bus.rom_wr   <= 1'b1;
              state_reg    <= WRITE;
            end
          end else if (bank_changed || !bus.rom_req) begin
            drop_reg <= 1'b1;
          end
        end

        WRITE: begin
          if (bank_changed) begin
            cnt_reg   <= '0;
            bus.busy  <= 1'b0;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            rearm_reg <= 1'b0;
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            state_reg <= DONE;
          end else if (!bus.rom_req) begin
            cnt_reg   <= '0;
            bus.busy  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= cnt_reg + 15'd1;
            state_reg <= ISSUE;
          end
        end

        DONE: begin
          // A still-high request for the same bank is the one just served
          if (!bus.rom_req) begin
            rearm_reg <= 1'b1;
          end else if (bank_changed || rearm_reg) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iecdrv_rom_fetch.sv
// Bench for iecdrv_rom_fetch: a randomized-latency memory responder plus a
// write scoreboard whose expected bytes come straight from the bank/offset
// address arithmetic, driven by one directed sequence of scenarios.
module tb_iecdrv_rom_fetch;
  import iecdrv_pkg::*;

  localparam int unsigned BASE = 32'h0100003;
  localparam int          NB   = 4;
  localparam int          AW   = 25;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  iecdrv_rom_fetch_if #(.ADDR_W(AW)) bus_if ();

  iecdrv_rom_fetch #(
    .BASE_ADDR(BASE),
    .NUM_BANKS(NB),
    .ADDR_W   (AW)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Scoreboard / responder state
  int          wr_count    = 0;
  int          wr_base     = 0;
  int          rd_rises    = 0;
  int          acks        = 0;
  int          lat_min     = 1;
  int          lat_max     = 1;
  int          exp_bank    = 0;
  bit          fill        = 1'b0;
  int          cyc         = 0;
  int          last_wr_cyc = -1;
  logic [AW-1:0] rise_addr = '0;
  logic [AW-1:0] ack_addr  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte the loader should receive at position idx of a bank's image
  function automatic logic [7:0] exp_byte(input int bank, input int idx);
    int unsigned a;
    if (fill) return 8'hFF;
    a = BASE + bank * 32768 + idx;
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_wr(input int n, input int bound);
    int k = 0;
    while ((wr_count - wr_base) < n && k < bound) begin
      step();
      k++;
    end
    if ((wr_count - wr_base) < n) chk("timeout_wr", wr_count - wr_base, n);
  endtask

  // Memory responder and write monitor, evaluated once per cycle
  initial begin : responder
    bit prev_ack;
    bit waiting;
    int wcnt;
    int lat;
    waiting = 1'b0;
    wcnt    = 0;
    lat     = 1;
    bus_if.mem_ack  = 1'b0;
    bus_if.mem_dout = 8'h00;
    forever begin
      @(negedge clk_sys);
      cyc++;
      prev_ack = bus_if.mem_ack;
      if (!reset && bus_if.rom_wr === 1'b1) begin
        $display("wr #%0d data=%02h", wr_count - wr_base, bus_if.rom_data);
        if (!fill) chk("ack_to_wr", {31'd0, prev_ack}, 1);
        if (!fill && lat_max == 1 && last_wr_cyc >= 0) chk("wr_spacing", cyc - last_wr_cyc, 3);
        chk("rom_data", bus_if.rom_data, exp_byte(exp_bank, wr_count - wr_base));
        last_wr_cyc = cyc;
        wr_count++;
      end
      bus_if.mem_ack = 1'b0;
      if (reset || bus_if.mem_rd !== 1'b1) begin
        if (waiting && !reset) chk("rd_held_to_ack", bus_if.mem_rd, 1);
        waiting = 1'b0;
      end else begin
        if (!waiting) begin
          waiting   = 1'b1;
          wcnt      = 0;
          rise_addr = bus_if.mem_addr;
          lat       = $urandom_range(lat_max, lat_min);
          rd_rises++;
        end else begin
          chk("addr_stable", bus_if.mem_addr, rise_addr);
        end
        wcnt++;
        if (wcnt == lat) begin
          bus_if.mem_ack  = 1'b1;
          bus_if.mem_dout = 8'(rise_addr) ^ 8'h5A;
          ack_addr        = rise_addr;
          waiting         = 1'b0;
          acks++;
        end
      end
    end
  end

  initial begin : main
    int k;
    int r0;
    int a0;
    int w0;
    bus_if.rom_req  = 1'b0;
    bus_if.rom_bank = 4'd0;
    reset = 1'b1;
    step();
    step();
    chk("rst_rom_wr",   bus_if.rom_wr,   0);
    chk("rst_rom_data", bus_if.rom_data, 0);
    chk("rst_mem_addr", bus_if.mem_addr, 0);
    chk("rst_mem_rd",   bus_if.mem_rd,   0);
    chk("rst_busy",     bus_if.busy,     0);
    chk("rst_done",     bus_if.done,     0);
    reset = 1'b0;
    step();

    // Full transfer of bank 2, ack latency 1
    exp_bank = 2; bus_if.rom_bank = 4'd2; wr_base = wr_count; last_wr_cyc = -1;
    bus_if.rom_req = 1'b1;
    k = 0;
    while (bus_if.mem_rd !== 1'b1 && k < 10) begin step(); k++; end
    chk("req_to_rd_cycles", k, 2);
    chk("first_addr_bank2", rise_addr, BASE + 65536);
    chk("busy_in_xfer", bus_if.busy, 1);
    chk("done_in_xfer", bus_if.done, 0);
    k = 0;
    while (bus_if.done !== 1'b1 && k < 110000) begin step(); k++; end
    chk("done_A", bus_if.done, 1);
    chk("busy_after_A", bus_if.busy, 0);
    chk("count_A", wr_count - wr_base, 32768);
    chk("last_addr_A", ack_addr, BASE + 98303);
    r0 = rd_rises;
    repeat (6) step();
    chk("no_restart_same_bank", rd_rises, r0);
    chk("done_held", bus_if.done, 1);
    bus_if.rom_req = 1'b0;
    repeat (3) step();

    // Bank 3, random latency, request dropped after 60 bytes
    lat_min = 1; lat_max = 20;
    exp_bank = 3; bus_if.rom_bank = 4'd3; wr_base = wr_count; last_wr_cyc = -1;
    bus_if.rom_req = 1'b1;
    wait_wr(60, 5000);
    bus_if.rom_req = 1'b0;
    chk("done_cleared", bus_if.done, 0);
    k = 0;
    while (bus_if.busy !== 1'b0 && k < 50) begin step(); k++; end
    repeat (10) step();
    chk("writes_after_req_drop", wr_count - wr_base, 60);
    chk("busy_after_drop", bus_if.busy, 0);

    // Bank change 0 -> 1 while waiting for byte 100
    lat_min = 5; lat_max = 5;
    exp_bank = 0; bus_if.rom_bank = 4'd0; wr_base = wr_count; last_wr_cyc = -1;
    bus_if.rom_req = 1'b1;
    wait_wr(100, 3000);
    k = 0;
    while (bus_if.mem_rd !== 1'b1 && k < 20) begin step(); k++; end
    chk("wait_at_cnt100_addr", rise_addr, BASE + 100);
    bus_if.rom_bank = 4'd1;
    r0 = rd_rises; a0 = acks; w0 = wr_count;
    exp_bank = 1; wr_base = wr_count; last_wr_cyc = -1;
    k = 0;
    while (rd_rises == r0 && k < 50) begin step(); k++; end
    chk("discard_ack_count", acks - a0, 1);
    chk("no_wr_after_bank_change", wr_count - w0, 0);
    chk("restart_addr_bank1", rise_addr, BASE + 32768);
    wait_wr(10, 500);

    // Asynchronous reset in the middle of a memory wait
    k = 0;
    while (bus_if.mem_rd !== 1'b1 && k < 20) begin step(); k++; end
    reset = 1'b1;
    #1;
    chk("arst_rom_wr",   bus_if.rom_wr,   0);
    chk("arst_rom_data", bus_if.rom_data, 0);
    chk("arst_mem_addr", bus_if.mem_addr, 0);
    chk("arst_mem_rd",   bus_if.mem_rd,   0);
    chk("arst_busy",     bus_if.busy,     0);
    chk("arst_done",     bus_if.done,     0);
    step();
    reset = 1'b0;
    wr_base = wr_count; last_wr_cyc = -1; r0 = rd_rises;
    k = 0;
    while (rd_rises == r0 && k < 20) begin step(); k++; end
    chk("addr_after_reset", rise_addr, BASE + 32768);
    chk("busy_after_reset", bus_if.busy, 1);
    wait_wr(5, 200);

    // Bank 7 with only NB banks present
    bus_if.rom_req = 1'b0;
    k = 0;
    while (bus_if.busy !== 1'b0 && k < 50) begin step(); k++; end
    step();
    lat_min = 1; lat_max = 3;
    exp_bank = 7; bus_if.rom_bank = 4'd7; wr_base = wr_count; last_wr_cyc = -1;
    r0 = rd_rises;
`ifdef IECDRV_FETCH_FILL_EN
    fill = 1'b1;
    bus_if.rom_req = 1'b1;
    k = 0;
    while (bus_if.done !== 1'b1 && k < 70000) begin step(); k++; end
    chk("fill_done", bus_if.done, 1);
    chk("fill_count", wr_count - wr_base, 32768);
    chk("fill_no_mem_rd", rd_rises, r0);
    bus_if.rom_req = 1'b0;
    step();
    fill = 1'b0;
`else
    bus_if.rom_req = 1'b1;
    wait_wr(8, 300);
    chk("bank7_addr", ack_addr, BASE + 7 * 32768 + 7);
    bus_if.rom_req = 1'b0;
    repeat (30) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iecdrv_rom_fetch.md
Name: iecdrv_rom_fetch

Overview:
- Upstream feeder for the drive ROM loader.
- Watches the loader's rom_req and streams the selected 32 KiB drive ROM image from the shared memory port (SDRAM/download buffer) as a sequence of one-cycle rom_wr/rom_data writes.
- Restarts automatically when the loader re-requests after a bank change or reset.
- Sits between the memory arbiter and the ROM loader, in the clk_sys domain.

Parameters:
- BASE_ADDR, 25'h0000000: memory byte address of bank 0; bank n starts at BASE_ADDR + n*32768.
- NUM_BANKS, 16: number of banks actually present in memory (1..16).
- ADDR_W, 25: memory address width.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_bank  in  4  selected ROM bank; same signal the loader sees.
- rom_req  in  1  loader wants bytes; high until 32768 bytes have been accepted.
- rom_wr  out  1  one-cycle write strobe to the loader.
- rom_data  out  8  byte qualified by rom_wr.
- mem_addr  out  ADDR_W  memory read address; stable while mem_rd is high.
- mem_rd  out  1  read request; held high until mem_ack.
- mem_ack  in  1  one-cycle pulse; mem_dout valid in the same cycle.
- mem_dout  in  8  read data.
- busy  out  1  a transfer is in progress.
- done  out  1  last bank transfer completed with all 32768 bytes.

Behaviour:
- Reset (asynchronous assertion; release synchronous to clk_sys):
  - state=IDLE, cnt=0, bank_q=0.
  - All outputs 0: rom_wr, rom_data, mem_addr, mem_rd, busy, done.
- cnt: 15-bit byte counter. bank_q: bank latched at transfer start.
- States:
  - IDLE: if rom_req, latch bank_q=rom_bank, set cnt=0, busy=1, done=0, go ISSUE.
  - ISSUE: drive mem_addr=BASE_ADDR+{bank_q,cnt}, set mem_rd=1, go WAIT. mem_rd rises exactly 2 cycles after rom_req is first sampled high.
  - WAIT: hold mem_rd and mem_addr. On mem_ack: mem_rd=0, capture mem_dout into rom_data, go WRITE. Wait is unbounded.
  - WRITE: rom_wr=1 for exactly this one cycle. If cnt==32767: done=1, busy=0, go DONE. Otherwise cnt+1, go ISSUE.
- Write spacing: minimum 3 cycles between rom_wr pulses when mem_ack arrives the cycle after mem_rd rises.
- rom_data holds its value until the next capture.
- DONE: idle. Leave DONE for IDLE when rom_req is high and either rom_bank differs from bank_q or rom_req is seen low then high again.
- Bank change mid-transfer (rom_bank != bank_q in ISSUE, WAIT or WRITE):
  - Suppress any pending rom_wr.
  - If mem_rd is high, keep it high until mem_ack and discard that data; the memory handshake is never abandoned.
  - Then go IDLE with cnt=0, done=0, and restart on rom_req.
- rom_req falling mid-transfer without a bank change: finish the outstanding memory read, drop the byte, go IDLE.
- Address arithmetic: ADDR_W-bit wrap-around; no overflow detection.
- Bank >= NUM_BANKS: memory is still read (modulo address) unless the optional feature is enabled.

Optional Feature:
- Macro: IECDRV_FETCH_FILL_EN.
- Defined: for bank_q >= NUM_BANKS, ISSUE/WAIT are skipped. rom_data=8'hFF and the machine goes straight to WRITE (rom_wr every 2 cycles), with no mem_rd activity. This lets the loader flag the bank as empty.
- Undefined: every bank reads memory as described above.

Decomposition:
- Shared package iecdrv_pkg:
  - ROM_BYTES=32768
  - ROM_AW=15
  - fetch_state_t enum {IDLE, ISSUE, WAIT, WRITE, DONE}
- No sub-module. The single FSM plus counter is the whole block; the address adder is inline.

Test Plan:
- Bank 2, mem_ack latency 1:
  - rom_req rises → mem_rd after 2 cycles; first mem_addr=BASE_ADDR+16'h0000_0+65536.
  - Exactly 32768 rom_wr pulses, last at mem_addr=BASE_ADDR+98303.
  - done=1, busy=0 afterwards.
- Data integrity: memory returns address low byte XOR 8'h5A → each rom_data matches in order, no duplicates, no gaps.
- Random mem_ack latency 1..20: mem_rd and mem_addr stay stable until ack, and every rom_wr follows its ack by exactly one cycle.
- rom_bank changes 0→1 while in WAIT at cnt=100:
  - Pending ack is consumed, no rom_wr is issued for it.
  - Restart reads BASE_ADDR+32768.
- Reset asserted mid-WAIT: all outputs 0 immediately (asynchronous); after release and rom_req, the transfer restarts from cnt=0.
- With IECDRV_FETCH_FILL_EN and NUM_BANKS=4, bank 7: 32768 writes of 8'hFF, mem_rd never asserted, done=1.
